// File: rtl/force_writeback_buffer.sv
// force_writeback_buffer
// Per-filter FIFO holding partial forces {pid, fz, fy, fx, dst} until the
// writeback arbiter accepts the head entry. The head is re-presented every
// cycle until force_cache_write_success, then popped.
// Optional build macro: FORCE_WB_BYPASS_EN. When it is defined, an entry
// arriving at an empty buffer is forwarded combinationally. If the arbiter
// grants it in that same cycle, the entry is never stored.
module force_writeback_buffer #(
   parameter int DATA_WIDTH         = 32,
   parameter int PARTICLE_ID_WIDTH  = 7,
   parameter int FORCE_BUFFER_WIDTH = 3*DATA_WIDTH + PARTICLE_ID_WIDTH + 1,
   parameter int DEPTH              = 8,
   parameter int PTR_WIDTH          = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [FORCE_BUFFER_WIDTH-1:0] in_force_data,
   input  logic                          in_force_valid,
   output logic                          in_ready,
   output logic [FORCE_BUFFER_WIDTH-1:0] force_data,
   output logic                          force_valid,
   input  logic                          force_cache_write_success,
   output logic [PTR_WIDTH:0]            fill_count,
   output logic                          overflow,
   output logic [15:0]                   retry_count
);

   localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

   logic [FORCE_BUFFER_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]          wr_ptr;
   logic [PTR_WIDTH-1:0]          rd_ptr;
   logic [PTR_WIDTH:0]            fill_next;
   logic                          stored_valid;
   logic                          push;
   logic                          push_store;
   logic                          pop;

   assign stored_valid = (fill_count != '0);
   assign push         = in_force_valid && in_ready;
   assign pop          = force_cache_write_success && stored_valid;

`ifdef FORCE_WB_BYPASS_EN
   logic bypass_take;

   // Forward an arriving entry to the arbiter when the buffer holds nothing.
   always_comb begin
      force_valid = stored_valid || in_force_valid;
      force_data  = '0;
      if (stored_valid)
         force_data = mem[rd_ptr];
      else if (in_force_valid)
         force_data = in_force_data;
   end

   // An entry granted in the cycle it arrives at an empty buffer is consumed
   // directly and never written into storage.
   assign bypass_take = !stored_valid && push && force_cache_write_success;
   assign push_store  = push && !bypass_take;
`else
   // Present the stored head, or zero when the buffer is empty.
   always_comb begin
      force_valid = stored_valid;
      force_data  = '0;
      if (stored_valid)
         force_data = mem[rd_ptr];
   end

   assign push_store = push;
`endif

   // Occupancy for the next cycle. A push and a pop in the same cycle cancel out.
   always_comb begin
      fill_next = fill_count;
      if (push_store && !pop)
         fill_next = fill_count + 1'b1;
      else if (!push_store && pop)
         fill_next = fill_count - 1'b1;
   end

   // Pointers, occupancy, ready and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_count <= '0;
         in_ready   <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         if (push_store)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fill_count <= fill_next;
         in_ready   <= (fill_next != FULL_CNT);
         if (in_force_valid && !in_ready)
            overflow <= 1'b1;
      end
   end

   // Entry storage. Reset flushes the buffer through the pointers, so the
   // storage array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push_store)
         mem[wr_ptr] <= in_force_data;
   end

   // Count the cycles the current head has waited ungranted, saturating at all ones.
   always_ff @(posedge clk) begin
      if (rst)
         retry_count <= '0;
      else if (!force_valid || force_cache_write_success)
         retry_count <= '0;
      else if (retry_count != 16'hFFFF)
         retry_count <= retry_count + 1'b1;
   end

endmodule

// File: tb/tb_force_writeback_buffer.sv
// tb_force_writeback_buffer
// Directed stimulus. Each accepted push places its expected entry in a
// queue. A negedge monitor pops the queue on every grant and checks the
// order of the entries the arbiter receives.
module tb_force_writeback_buffer;

   localparam int W  = 3*32 + 7 + 1;
   localparam int PW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  in_force_data;
   logic          in_force_valid;
   logic          in_ready;
   logic [W-1:0]  force_data;
   logic          force_valid;
   logic          force_cache_write_success;
   logic [PW:0]   fill_count;
   logic          overflow;
   logic [15:0]   retry_count;

   int            checks   = 0;
   int            failures = 0;
   logic [W-1:0]  exp_q [$];
   logic [W-1:0]  ent_a;
   logic [W-1:0]  ent_e [20];

   force_writeback_buffer dut (
      .clk                       (clk),
      .rst                       (rst),
      .in_force_data             (in_force_data),
      .in_force_valid            (in_force_valid),
      .in_ready                  (in_ready),
      .force_data                (force_data),
      .force_valid               (force_valid),
      .force_cache_write_success (force_cache_write_success),
      .fill_count                (fill_count),
      .overflow                  (overflow),
      .retry_count               (retry_count)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input logic [6:0] pid, input logic [31:0] fz,
                                       input logic [31:0] fy, input logic [31:0] fx,
                                       input logic dst);
      return {pid, fz, fy, fx, dst};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: each grant of a valid head must deliver the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && force_valid && force_cache_write_success) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_pop: got %0h expected nothing queued", force_data);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (force_data !== e) begin
               failures++;
               $display("FAIL sb_order: got %0h expected %0h", force_data, e);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 20; i++)
         ent_e[i] = mk(7'(i + 16), 32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
                       32'h3000_0000 + 32'(i), i[0]);
      ent_a = mk(7'h05, 32'h3F80_0000, 32'h0, 32'hBF80_0000, 1'b1);

      rst = 1'b1;
      in_force_data = '0;
      in_force_valid = 1'b0;
      force_cache_write_success = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_fill", W'(fill_count), W'(0));
      chk("rst_ready", W'(in_ready), W'(1));
      chk("rst_valid", W'(force_valid), W'(0));
      chk("rst_data", force_data, W'(0));
      chk("rst_ovf", W'(overflow), W'(0));
      chk("rst_retry", W'(retry_count), W'(0));

      // Single push, held 10 ungranted cycles
      in_force_data = ent_a;
      in_force_valid = 1'b1;
      exp_q.push_back(ent_a);
      tick();
      in_force_valid = 1'b0;
      chk("a_valid", W'(force_valid), W'(1));
      chk("a_data", force_data, ent_a);
      chk("a_retry0", W'(retry_count), W'(0));
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("a_hold", force_data, ent_a);
      end
      chk("a_retry10", W'(retry_count), W'(10));
      force_cache_write_success = 1'b1;
      tick();
      force_cache_write_success = 1'b0;
      chk("a_popped_fill", W'(fill_count), W'(0));
      chk("a_retry_clr", W'(retry_count), W'(0));

      // Fill to full, then one push while full
      for (int i = 0; i < 8; i++) begin
         in_force_data = ent_e[i];
         in_force_valid = 1'b1;
         exp_q.push_back(ent_e[i]);
         tick();
      end
      chk("full_fill", W'(fill_count), W'(8));
      chk("full_ready", W'(in_ready), W'(0));
      chk("full_ovf0", W'(overflow), W'(0));
      in_force_data = mk(7'h7F, '1, '1, '1, 1'b0);
      tick();
      in_force_valid = 1'b0;
      chk("drop_fill", W'(fill_count), W'(8));
      chk("drop_ovf", W'(overflow), W'(1));
      chk("drop_head", force_data, ent_e[0]);

      // Drain with concurrent pushes across the pointer wrap
      force_cache_write_success = 1'b1;
      tick();
      chk("drain1_fill", W'(fill_count), W'(7));
      chk("drain1_ready", W'(in_ready), W'(1));
      for (int i = 8; i < 20; i++) begin
         in_force_data = ent_e[i];
         in_force_valid = 1'b1;
         exp_q.push_back(ent_e[i]);
         tick();
         chk("steady_fill", W'(fill_count), W'(7));
      end
      in_force_valid = 1'b0;
      for (int i = 0; i < 7; i++)
         tick();
      chk("drained_fill", W'(fill_count), W'(0));
      chk("drained_valid", W'(force_valid), W'(0));
      chk("sb_empty", W'(exp_q.size()), W'(0));

      // Grant while empty is ignored
      tick();
      tick();
      force_cache_write_success = 1'b0;
      chk("empty_gnt_fill", W'(fill_count), W'(0));
      chk("empty_gnt_valid", W'(force_valid), W'(0));
      chk("empty_gnt_data", force_data, W'(0));
      in_force_data = ent_e[3];
      in_force_valid = 1'b1;
      exp_q.push_back(ent_e[3]);
      tick();
      in_force_valid = 1'b0;
      chk("ptr_kept_data", force_data, ent_e[3]);

      // Reset mid-stream flushes all entries and clears overflow
      for (int i = 0; i < 4; i++) begin
         in_force_data = ent_e[i + 10];
         in_force_valid = 1'b1;
         tick();
      end
      in_force_valid = 1'b0;
      chk("pre_rst_fill", W'(fill_count), W'(5));
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
      chk("mid_rst_fill", W'(fill_count), W'(0));
      chk("mid_rst_valid", W'(force_valid), W'(0));
      chk("mid_rst_ovf", W'(overflow), W'(0));
      chk("mid_rst_ready", W'(in_ready), W'(1));
      tick();
      chk("post_rst_data", force_data, W'(0));

`ifdef FORCE_WB_BYPASS_EN
      // Same-cycle bypass into a granting arbiter
      in_force_data = ent_e[15];
      in_force_valid = 1'b1;
      force_cache_write_success = 1'b1;
      exp_q.push_back(ent_e[15]);
      #1;
      chk("byp_valid", W'(force_valid), W'(1));
      chk("byp_data", force_data, ent_e[15]);
      tick();
      in_force_valid = 1'b0;
      force_cache_write_success = 1'b0;
      chk("byp_fill", W'(fill_count), W'(0));
      chk("byp_sb_empty", W'(exp_q.size()), W'(0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
